// File: rtl/memory_access_unit_pkg.sv
// memory_access_unit_pkg: shared widths, op codes and helpers for the MEM stage
//   DATA_SIZE / GPR_SIZE / OP_WB_SIZE / MEM_OP_SIZE : bus widths
//   wb_e     : writeback target codes
//   mem_op_e : memory operation codes (2'b11 reserved, treated as none)
package memory_access_unit_pkg;
   localparam int DATA_SIZE   = 32;
   localparam int GPR_SIZE    = 5;
   localparam int OP_WB_SIZE  = 2;
   localparam int MEM_OP_SIZE = 2;
   typedef enum logic [OP_WB_SIZE-1:0] {
      WB_NONE     = 2'b00,
      WB_REGISTER = 2'b01,
      WB_MEMORY   = 2'b10
   } wb_e;
   typedef enum logic [MEM_OP_SIZE-1:0] {
      MEM_NONE     = 2'b00,
      MEM_LOAD     = 2'b01,
      MEM_STORE    = 2'b10,
      MEM_RESERVED = 2'b11
   } mem_op_e;
   function automatic logic is_access(input logic [MEM_OP_SIZE-1:0] op);
      return op == MEM_LOAD || op == MEM_STORE;
   endfunction
endpackage

// File: rtl/memory_access_unit_if.sv
// memory_access_unit_if: data-memory req/ack bus
//   master (MEM stage): drives mem_req, mem_we, mem_addr, mem_wdata; samples mem_ack, mem_rdata
//   slave  (memory)   : the mirror image
interface memory_access_unit_if
   import memory_access_unit_pkg::*;
   ();
   logic                 mem_req;
   logic                 mem_we;
   logic [DATA_SIZE-1:0] mem_addr;
   logic [DATA_SIZE-1:0] mem_wdata;
   logic                 mem_ack;
   logic [DATA_SIZE-1:0] mem_rdata;
   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );
   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/memory_access_unit_timeout_counter.sv
// mem_timeout_counter: saturating access timer, flags the last allowed cycle
//   clk, rst_n : clock, async active-low reset
//   clear      : zero the timer
//   enable     : count this cycle
//   expired    : timer has reached TIMEOUT_CYCLES - 1
module mem_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMER_SIZE     = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam logic [TIMER_SIZE-1:0] LIMIT = TIMER_SIZE'(TIMEOUT_CYCLES - 1);
   logic [TIMER_SIZE-1:0] count;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count <= '0;
      else if (clear) count <= '0;
      else if (enable && count != '1) count <= count + TIMER_SIZE'(1);
   end
   assign expired = count == LIMIT;
endmodule

// File: rtl/memory_access_unit.sv
// memory_access_unit: MEM pipeline stage performing loads/stores between execute and write-back
//   clk, rst_n      : clock, async active-low reset
//   in_valid/ready  : execute handshake (ready only in IDLE)
//   ex_*            : execute result bundle and memory op
//   mem             : data-memory req/ack bus (master side)
//   wb_valid + result/destination/writeback/data_in : registered bundle to write-back
//   bus_error       : one-cycle pulse on access timeout
module memory_access_unit
   import memory_access_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMER_SIZE     = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_SIZE-1:0]   ex_result,
   input  logic [GPR_SIZE-1:0]    ex_destination,
   input  logic [OP_WB_SIZE-1:0]  ex_writeback,
   input  logic [MEM_OP_SIZE-1:0] ex_mem_op,
   input  logic [DATA_SIZE-1:0]   ex_store_data,
   memory_access_unit_if.master   mem,
   output logic                   wb_valid,
   output logic [DATA_SIZE-1:0]   result,
   output logic [GPR_SIZE-1:0]    destination,
   output logic [OP_WB_SIZE-1:0]  writeback,
   output logic [DATA_SIZE-1:0]   data_in,
   output logic                   bus_error
);
   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;
   state_e                  state, state_nxt;
   logic                    req_nxt, we_nxt, wb_valid_nxt, bus_error_nxt, expired;
   logic                    lat_load, lat_load_nxt;
   logic [DATA_SIZE-1:0]    addr_nxt, wdata_nxt, result_nxt, data_in_nxt;
   logic [GPR_SIZE-1:0]     dest_nxt, lat_dest, lat_dest_nxt;
   logic [OP_WB_SIZE-1:0]   writeback_nxt, lat_wb, lat_wb_nxt;
   mem_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .TIMER_SIZE    (TIMER_SIZE)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (state == IDLE),
      .enable (state == ACCESS),
      .expired(expired)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         in_ready      <= 1'b0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         wb_valid      <= 1'b0;
         result        <= '0;
         destination   <= '0;
         writeback     <= WB_NONE;
         data_in       <= '0;
         bus_error     <= 1'b0;
         lat_dest      <= '0;
         lat_wb        <= WB_NONE;
         lat_load      <= 1'b0;
      end else begin
         state         <= state_nxt;
         in_ready      <= state_nxt == IDLE;
         mem.mem_req   <= req_nxt;
         mem.mem_we    <= we_nxt;
         mem.mem_addr  <= addr_nxt;
         mem.mem_wdata <= wdata_nxt;
         wb_valid      <= wb_valid_nxt;
         result        <= result_nxt;
         destination   <= dest_nxt;
         writeback     <= writeback_nxt;
         data_in       <= data_in_nxt;
         bus_error     <= bus_error_nxt;
         lat_dest      <= lat_dest_nxt;
         lat_wb        <= lat_wb_nxt;
         lat_load      <= lat_load_nxt;
      end
   end
   always_comb begin
      state_nxt     = state;
      req_nxt       = mem.mem_req;
      we_nxt        = mem.mem_we;
      addr_nxt      = mem.mem_addr;
      wdata_nxt     = mem.mem_wdata;
      wb_valid_nxt  = 1'b0;
      result_nxt    = '0;
      dest_nxt      = '0;
      writeback_nxt = WB_NONE;
      data_in_nxt   = '0;
      bus_error_nxt = 1'b0;
      lat_dest_nxt  = lat_dest;
      lat_wb_nxt    = lat_wb;
      lat_load_nxt  = lat_load;
      if (state == IDLE) begin
         if (in_ready && in_valid) begin
            if (is_access(ex_mem_op)) begin
               state_nxt    = ACCESS;
               req_nxt      = 1'b1;
               we_nxt       = ex_mem_op == MEM_STORE;
               addr_nxt     = ex_result;
               wdata_nxt    = ex_store_data;
               lat_dest_nxt = ex_destination;
               lat_wb_nxt   = ex_writeback;
               lat_load_nxt = ex_mem_op == MEM_LOAD;
            end else begin
               wb_valid_nxt  = 1'b1;
               result_nxt    = ex_result;
               dest_nxt      = ex_destination;
               writeback_nxt = ex_writeback;
            end
         end
      end else if (mem.mem_ack || expired) begin
         // mem_addr still holds the latched ex_result, so it doubles as the result
         state_nxt     = IDLE;
         req_nxt       = 1'b0;
         wb_valid_nxt  = 1'b1;
         result_nxt    = mem.mem_addr;
         dest_nxt      = lat_dest;
         bus_error_nxt = !mem.mem_ack;
         writeback_nxt = mem.mem_ack && lat_load ? lat_wb : WB_NONE;
         data_in_nxt   = mem.mem_ack && lat_load ? mem.mem_rdata : '0;
      end
   end
endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: scoreboard bench for memory_access_unit (TIMEOUT_CYCLES = 4)
module tb_memory_access_unit;
   import memory_access_unit_pkg::*;
   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  dest;
      logic [1:0]  wb;
      logic [31:0] data;
      logic        err;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] ex_result, ex_store_data;
   logic [4:0]  ex_destination;
   logic [1:0]  ex_writeback, ex_mem_op;
   logic        wb_valid, bus_error;
   logic [31:0] result, data_in;
   logic [4:0]  destination;
   logic [1:0]  writeback;
   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];
   exp_t        e;
   memory_access_unit_if mem_bus();
   memory_access_unit #(.TIMEOUT_CYCLES(4), .TIMER_SIZE(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .ex_result     (ex_result),
      .ex_destination(ex_destination),
      .ex_writeback  (ex_writeback),
      .ex_mem_op     (ex_mem_op),
      .ex_store_data (ex_store_data),
      .mem           (mem_bus.master),
      .wb_valid      (wb_valid),
      .result        (result),
      .destination   (destination),
      .writeback     (writeback),
      .data_in       (data_in),
      .bus_error     (bus_error)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      if (rst_n) begin
         if (wb_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_wb: got wb_valid with result %0h, expected none", result);
            end else begin
               e = sb.pop_front();
               check("wb_result", result, e.result);
               check("wb_destination", {27'd0, destination}, {27'd0, e.dest});
               check("wb_writeback", {30'd0, writeback}, {30'd0, e.wb});
               check("wb_data_in", data_in, e.data);
               check("wb_bus_error", {31'd0, bus_error}, {31'd0, e.err});
            end
         end else begin
            check("idle_writeback", {30'd0, writeback}, {30'd0, WB_NONE});
            check("idle_bus_error", {31'd0, bus_error}, 32'd0);
         end
      end
   end
   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      check("ready_wait", {31'd0, in_ready}, 32'd1);
   endtask
   task automatic send_alu(input logic [31:0] res, input logic [4:0] dst, input logic [1:0] wb,
                           input logic [1:0] op);
      sb.push_back('{result: res, dest: dst, wb: wb, data: 32'h0, err: 1'b0});
      in_valid       = 1'b1;
      ex_result      = res;
      ex_destination = dst;
      ex_writeback   = wb;
      ex_mem_op      = op;
      ex_store_data  = 32'h5555_AAAA;
      check("alu_in_ready", {31'd0, in_ready}, 32'd1);
      step();
   endtask
   task automatic send_mem(input logic [1:0] op, input logic [31:0] addr, input logic [4:0] dst,
                           input logic [1:0] wb, input logic [31:0] wdata, input int ack_at,
                           input logic [31:0] rdata, input int exp_cycles, input logic exp_we,
                           input logic [1:0] exp_wb, input logic [31:0] exp_data,
                           input logic exp_err);
      int cnt = 0;
      wait_ready();
      sb.push_back('{result: addr, dest: dst, wb: exp_wb, data: exp_data, err: exp_err});
      in_valid       = 1'b1;
      ex_result      = addr;
      ex_destination = dst;
      ex_writeback   = wb;
      ex_mem_op      = op;
      ex_store_data  = wdata;
      step();
      in_valid = 1'b0;
      while (mem_bus.mem_req && cnt < 50) begin
         cnt++;
         check("mem_addr", mem_bus.mem_addr, addr);
         check("mem_we", {31'd0, mem_bus.mem_we}, {31'd0, exp_we});
         check("mem_wdata", mem_bus.mem_wdata, wdata);
         check("busy_in_ready", {31'd0, in_ready}, 32'd0);
         if (cnt == ack_at) begin
            mem_bus.mem_ack   = 1'b1;
            mem_bus.mem_rdata = rdata;
         end
         step();
         mem_bus.mem_ack   = 1'b0;
         mem_bus.mem_rdata = 32'h0;
      end
      check("req_cycles", cnt, exp_cycles);
      check("done_in_ready", {31'd0, in_ready}, 32'd1);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
   initial begin
      rst_n             = 1'b0;
      in_valid          = 1'b0;
      ex_result         = 32'h0;
      ex_destination    = 5'd0;
      ex_writeback      = WB_NONE;
      ex_mem_op         = MEM_NONE;
      ex_store_data     = 32'h0;
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = 32'h0;
      #2;
      check("rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
      check("rst_mem_addr", mem_bus.mem_addr, 32'd0);
      check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rst_writeback", {30'd0, writeback}, {30'd0, WB_NONE});
      check("rst_bus_error", {31'd0, bus_error}, 32'd0);
      check("rst_result", result, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      wait_ready();
      // back-to-back ALU ops, with a stray ack that must be ignored in IDLE
      mem_bus.mem_ack = 1'b1;
      send_alu(32'h11, 5'd1, WB_REGISTER, MEM_NONE);
      send_alu(32'h22, 5'd2, WB_REGISTER, MEM_NONE);
      send_alu(32'h33, 5'd3, WB_REGISTER, MEM_NONE);
      send_alu(32'h44, 5'd7, WB_REGISTER, MEM_RESERVED);
      mem_bus.mem_ack = 1'b0;
      in_valid        = 1'b0;
      check("alu_no_req", {31'd0, mem_bus.mem_req}, 32'd0);
      step();
      step();
      // load, ack on the 3rd request cycle
      send_mem(MEM_LOAD, 32'h100, 5'd5, WB_MEMORY, 32'h0, 3, 32'hDEADBEEF, 3, 1'b0,
               WB_MEMORY, 32'hDEADBEEF, 1'b0);
      // store, ack on the 2nd request cycle; writeback forced to none
      send_mem(MEM_STORE, 32'h40, 5'd6, WB_MEMORY, 32'hCAFE, 2, 32'hFFFF_FFFF, 2, 1'b1,
               WB_NONE, 32'h0, 1'b0);
      // load with no ack: timeout after 4 request cycles
      send_mem(MEM_LOAD, 32'h80, 5'd8, WB_REGISTER, 32'h0, 0, 32'h0, 4, 1'b0,
               WB_NONE, 32'h0, 1'b1);
      wait_ready();
      send_alu(32'h99, 5'd4, WB_REGISTER, MEM_NONE);
      in_valid = 1'b0;
      step();
      // ack on the last allowed cycle wins over timeout
      send_mem(MEM_LOAD, 32'hC0, 5'd10, WB_MEMORY, 32'h0, 4, 32'h1234_5678, 4, 1'b0,
               WB_MEMORY, 32'h1234_5678, 1'b0);
      // reset in the middle of an access
      wait_ready();
      in_valid       = 1'b1;
      ex_result      = 32'h200;
      ex_destination = 5'd11;
      ex_writeback   = WB_MEMORY;
      ex_mem_op      = MEM_LOAD;
      step();
      in_valid = 1'b0;
      step();
      check("mid_req", {31'd0, mem_bus.mem_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_req", {31'd0, mem_bus.mem_req}, 32'd0);
      check("async_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("async_rst_bus_error", {31'd0, bus_error}, 32'd0);
      step();
      rst_n             = 1'b1;
      mem_bus.mem_ack   = 1'b1;
      mem_bus.mem_rdata = 32'hBAD0_BAD0;
      step();
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = 32'h0;
      check("late_ack_req", {31'd0, mem_bus.mem_req}, 32'd0);
      check("late_ack_wb_valid", {31'd0, wb_valid}, 32'd0);
      send_mem(MEM_LOAD, 32'h300, 5'd9, WB_MEMORY, 32'h0, 2, 32'h0BAD_F00D, 2, 1'b0,
               WB_MEMORY, 32'h0BAD_F00D, 1'b0);
      step();
      step();
      check("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
